// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the CORDIC front end.
// Select bit indices, angle constants and the select resolver.
package cordic_pkg;

    localparam int CORDIC_W     = 24;
    localparam int CORDIC_TAG_W = 4;

    localparam int SEL_SIN = 0;
    localparam int SEL_COS = 1;
    localparam int SEL_TAN = 2;
    localparam int SEL_ANG = 3;

    localparam logic [23:0] ANGLE_PI      = 24'h800000;
    localparam logic [23:0] ANGLE_HALF_PI = 24'h400000;
    localparam logic [23:0] X_INIT        = 24'h400000;

    // Isolate the lowest set bit: [0] wins over [1] over [2] over [3].
    function automatic logic [3:0] sel_resolve(input logic [3:0] s);
        return s & (~s + 4'd1);
    endfunction

endpackage

// File: rtl/cordic_input_stage_if.sv
// Request-side and core-side valid/ready bundles of the CORDIC front end.
// The master drives valid and payload; the slave drives ready.
interface cordic_req_if #(
    parameter int W = 24
);
    logic         valid;
    logic         ready;
    logic [3:0]   select;
    logic [W-1:0] angle;
    logic [W-1:0] x;
    logic [W-1:0] y;

    modport master (output valid, select, angle, x, y, input ready);
    modport slave  (input valid, select, angle, x, y, output ready);
endinterface

interface cordic_core_if #(
    parameter int W     = 24,
    parameter int TAG_W = 4
);
    logic             valid;
    logic             ready;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic [W-1:0]     z;
    logic [3:0]       select;
    logic             neg;
    logic [TAG_W-1:0] tag;

    modport master (output valid, x, y, z, select, neg, tag, input ready);
    modport slave  (input valid, x, y, z, select, neg, tag, output ready);
endinterface

// File: rtl/cordic_pipe_slice.sv
// Generic valid/ready register slice carrying an opaque payload.
// Loads whenever empty or draining, so it sustains one beat per cycle.
module cordic_pipe_slice #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/cordic_input_stage.sv
// CORDIC front end: select resolution, quadrant reduction, sequence tagging.
// S1 captures the request, S2 holds the reduced x0/y0/z0 for the core.
module cordic_input_stage #(
    parameter int                 W      = cordic_pkg::CORDIC_W,
    parameter logic [W-1:0]       X_INIT = cordic_pkg::X_INIT,
    parameter int                 TAG_W  = cordic_pkg::CORDIC_TAG_W
) (
    input  logic          clk,
    input  logic          rst_n,
    cordic_req_if.slave   req,
    cordic_core_if.master core,
    output logic          err_drop
);
    import cordic_pkg::*;

    localparam logic [W-1:0] PI   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [3:0]       sel;
        logic [W-1:0]     angle;
        logic [W-1:0]     x;
        logic [W-1:0]     y;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic [W-1:0]     x;
        logic [W-1:0]     y;
        logic [W-1:0]     z;
        logic [3:0]       sel;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } s2_t;

    // The most negative value has no positive twin; clamp it.
    function automatic logic [W-1:0] sat_neg(input logic [W-1:0] v);
        return (v == PI) ? MAXP : (~v + ONE);
    endfunction

    logic [TAG_W-1:0] tag_q;
    logic             s1_in_valid;
    logic             s1_in_ready;
    logic             s1_valid;
    logic             s2_in_ready;
    s1_t              s1_d;
    s1_t              s1_q;
    s2_t              s2_d;
    s2_t              s2_q;

    assign s1_in_valid = req.valid && (req.select != 4'd0);
    assign req.ready   = s1_in_ready;

    always_comb begin
        s1_d       = '0;
        s1_d.sel   = sel_resolve(req.select);
        s1_d.angle = req.angle;
        s1_d.x     = req.x;
        s1_d.y     = req.y;
        s1_d.tag   = tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            err_drop <= 1'b0;
        end else begin
            err_drop <= req.valid && s1_in_ready && (req.select == 4'd0);
            if (s1_in_valid && s1_in_ready) begin
                tag_q <= tag_q + TAG_W'(1);
            end
        end
    end

    cordic_pipe_slice #(.PW($bits(s1_t))) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .in_data   (s1_d),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_q)
    );

    // Angles outside [-pi/2, pi/2) are folded by pi; the sign is fixed later.
    always_comb begin
        s2_d     = '0;
        s2_d.sel = s1_q.sel;
        s2_d.tag = s1_q.tag;
        if (s1_q.sel[SEL_ANG]) begin
            if (s1_q.x[W-1]) begin
                s2_d.x = sat_neg(s1_q.x);
                s2_d.y = sat_neg(s1_q.y);
                s2_d.z = PI;
            end else begin
                s2_d.x = s1_q.x;
                s2_d.y = s1_q.y;
            end
        end else begin
            s2_d.x = X_INIT;
            if (s1_q.angle[W-1] ^ s1_q.angle[W-2]) begin
                s2_d.z   = s1_q.angle + PI;
                s2_d.neg = 1'b1;
            end else begin
                s2_d.z = s1_q.angle;
            end
        end
    end

    cordic_pipe_slice #(.PW($bits(s2_t))) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_d),
        .out_valid (core.valid),
        .out_ready (core.ready),
        .out_data  (s2_q)
    );

    assign core.x      = s2_q.x;
    assign core.y      = s2_q.y;
    assign core.z      = s2_q.z;
    assign core.select = s2_q.sel;
    assign core.neg    = s2_q.neg;
    assign core.tag    = s2_q.tag;

endmodule

// File: tb/tb_cordic_input_stage.sv
// Bench for cordic_input_stage: reference model queue plus directed vectors.
// Outputs are sampled on the falling edge; inputs change just after rising.
module tb_cordic_input_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_drop;

    cordic_req_if  #(.W(24))             req ();
    cordic_core_if #(.W(24), .TAG_W(4))  core ();

    cordic_input_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .core     (core),
        .err_drop (err_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] x;
        logic [23:0] y;
        logic [23:0] z;
        logic [3:0]  sel;
        logic        neg;
        logic [3:0]  tag;
    } exp_t;

    int         n_chk = 0;
    int         n_fail = 0;
    exp_t       q[$];
    logic [3:0] seen[$];
    int         mtag = 0;
    int         drop_cnt = 0;
    logic       exp_drop = 1'b0;
    logic       hold_prev = 1'b0;
    exp_t       last_out;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] sneg(input int v);
        int r = -v;
        if (r > 8388607) r = 8388607;
        return 24'(r);
    endfunction

    // Spec-level model: quadrant rule in signed integer terms.
    function automatic exp_t model(input logic [3:0] s, input logic [23:0] a,
                                   input logic [23:0] x, input logic [23:0] y,
                                   input int tag);
        exp_t e;
        int idx = -1;
        int ai, xi, yi;
        e = '0;
        for (int i = 3; i >= 0; i--) if (s[i]) idx = i;
        e.sel = 4'(1 << idx);
        e.tag = 4'(tag);
        ai = int'($signed(a));
        xi = int'($signed(x));
        yi = int'($signed(y));
        if (idx < 3) begin
            e.x = 24'h400000;
            if (ai >= 4194304 || ai < -4194304) begin
                e.z   = 24'(ai + 8388608);
                e.neg = 1'b1;
            end else begin
                e.z = a;
            end
        end else if (xi < 0) begin
            e.x = sneg(xi);
            e.y = sneg(yi);
            e.z = 24'h800000;
        end else begin
            e.x = x;
            e.y = y;
        end
        return e;
    endfunction

    function automatic exp_t cur_out();
        exp_t c;
        c.x = core.x; c.y = core.y; c.z = core.z;
        c.sel = core.select; c.neg = core.neg; c.tag = core.tag;
        return c;
    endfunction

    always @(negedge clk) begin
        exp_t c, e;
        c = cur_out();
        if (!rst_n) begin
            q.delete();
            mtag = 0;
            exp_drop = 1'b0;
            hold_prev = 1'b0;
        end else begin
            chk("err_drop", err_drop, exp_drop);
            drop_cnt += int'(err_drop);
            if (hold_prev) chk("hold", c, last_out);
            if (core.valid && core.ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out", c, e);
                    seen.push_back(core.tag);
                end
            end
            hold_prev = core.valid && !core.ready;
            last_out = c;
            exp_drop = req.valid && req.ready && (req.select == 4'd0);
            if (req.valid && req.ready && req.select != 4'd0) begin
                q.push_back(model(req.select, req.angle, req.x, req.y, mtag));
                mtag = (mtag + 1) % 16;
            end
        end
    end

    task automatic send(input logic [3:0] s, input logic [23:0] a,
                        input logic [23:0] x, input logic [23:0] y);
        int n = 0;
        req.valid = 1'b1; req.select = s;
        req.angle = a; req.x = x; req.y = y;
        @(negedge clk);
        while (!req.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req.ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic single(input string nm, input logic [3:0] s,
                          input logic [23:0] a, input logic [23:0] x,
                          input logic [23:0] y, input logic [23:0] ex,
                          input logic [23:0] ey, input logic [23:0] ez,
                          input logic en, input logic [3:0] es);
        send(s, a, x, y);
        req.valid = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_valid"}, core.valid, 1'b1);
        chk({nm, "_x"}, core.x, ex);
        chk({nm, "_y"}, core.y, ey);
        chk({nm, "_z"}, core.z, ez);
        chk({nm, "_neg"}, core.neg, en);
        chk({nm, "_sel"}, core.select, es);
    endtask

    task automatic rst_pulse();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen.delete();
    endtask

    initial begin
        req.valid = 1'b0; req.select = 4'd0;
        req.angle = '0; req.x = '0; req.y = '0;
        core.ready = 1'b1;
        #12;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_valid", core.valid, 1'b0);
        chk("rst_fields", cur_out(), 81'd0);
        chk("rst_err", err_drop, 1'b0);
        chk("rst_ready", req.ready, 1'b1);

        send(4'b0001, 24'h200000, 24'h0, 24'h0);
        req.valid = 1'b0;
        chk("lat_1cyc", core.valid, 1'b0);
        @(posedge clk); #1;
        chk("sin_valid", core.valid, 1'b1);
        chk("sin_out", cur_out(),
            {24'h400000, 24'h0, 24'h200000, 4'b0001, 1'b0, 4'd0});

        single("cos34", 4'b0010, 24'h600000, 0, 0,
               24'h400000, 24'h0, 24'hE00000, 1'b1, 4'b0010);
        single("cos12", 4'b0010, 24'h400000, 0, 0,
               24'h400000, 24'h0, 24'hC00000, 1'b1, 4'b0010);
        single("cospi", 4'b0010, 24'h800000, 0, 0,
               24'h400000, 24'h0, 24'h000000, 1'b1, 4'b0010);
        single("tanm12", 4'b0100, 24'hC00000, 0, 0,
               24'h400000, 24'h0, 24'hC00000, 1'b0, 4'b0100);
        single("ang", 4'b1000, 0, 24'hC00000, 24'h100000,
               24'h400000, 24'hF00000, 24'h800000, 1'b0, 4'b1000);
        single("angsat", 4'b1000, 0, 24'h800000, 24'h0,
               24'h7FFFFF, 24'h0, 24'h800000, 1'b0, 4'b1000);
        single("angpos", 4'b1000, 0, 24'h300000, 24'h123456,
               24'h300000, 24'h123456, 24'h0, 1'b0, 4'b1000);

        rst_pulse();
        core.ready = 1'b0;
        send(4'b0001, 24'h100000, 0, 0);
        send(4'b0010, 24'h500000, 0, 0);
        req.select = 4'b0100; req.angle = 24'hA00000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready_low", req.ready, 1'b0);
        end
        @(posedge clk); #1;
        core.ready = 1'b1;
        send(4'b0100, 24'hA00000, 0, 0);
        send(4'b1000, 0, 24'hF00000, 24'h800000);
        req.valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", seen.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) chk("bp_tag", seen[i], i);
        end

        rst_pulse();
        drop_cnt = 0;
        send(4'b0000, 24'h100000, 0, 0);
        send(4'b0001, 24'h100000, 0, 0);
        req.valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("drop_pulses", drop_cnt, 1);
        chk("drop_count", seen.size(), 1);
        if (seen.size() > 0) chk("drop_tag", seen[0], 0);
        single("prio", 4'b0110, 24'h0, 0, 0,
               24'h400000, 24'h0, 24'h0, 1'b0, 4'b0010);

        rst_pulse();
        for (int i = 0; i < 17; i++) begin
            send(4'b0001, 24'(i * 24'h030000), 0, 0);
        end
        req.valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("wrap_count", seen.size(), 17);
        if (seen.size() == 17) begin
            chk("wrap_tag15", seen[15], 15);
            chk("wrap_tag16", seen[16], 0);
        end

        core.ready = 1'b0;
        send(4'b0001, 24'h200000, 0, 0);
        req.valid = 1'b0;
        @(posedge clk); #1;
        chk("s2_full", core.valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("flush_valid", core.valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        core.ready = 1'b1;
        seen.delete();
        send(4'b0001, 24'h200000, 0, 0);
        req.valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_count", seen.size(), 1);
        if (seen.size() > 0) chk("post_rst_tag", seen[0], 0);

        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
